store_buffer: RTL
=================

Name: store_buffer

Overview:
- Sits directly downstream of the retire stage and consumes its committed store stream: write pulse, size, write address and store data.
- Queues stores in a small in-order FIFO, aligns them to 32-bit memory lanes with byte enables, and drains them to the data memory over a req/gnt handshake.
- Flags loads that alias a pending store so the load path can stall.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- st_valid  in  1  committed store pulse from retire (its write output)
- st_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- st_addr  in  32  byte address from retire
- st_data  in  32  store data from retire; LSB-justified
- st_full  out  1  buffer holds DEPTH entries
- st_empty  out  1  no queued or in-flight entry
- misaligned  out  1  one-cycle pulse: last store rejected
- overflow  out  1  sticky: a store arrived while full
- mem_req  out  1  memory write request
- mem_addr  out  32  word address, bits[1:0]=00
- mem_wdata  out  32  lane-aligned data
- mem_be  out  4  byte enables
- mem_gnt  in  1  memory accepts the request this cycle
- ld_addr  in  32  address of the load currently in execute
- ld_hazard  out  1  load word matches a pending store word

Behaviour:
- Reset (async, active-low):
  - Pointers and count cleared; FSM to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - misaligned=0, overflow=0, st_empty=1, st_full=0.
  - Reset asserted mid-request drops mem_req immediately; queued stores are discarded.
- Enqueue, on the clk edge where st_valid=1:
  - Accepted if count<DEPTH and the alignment check passes.
  - Same-cycle pop does not free space for the push; st_full = (count==DEPTH).
- Alignment:
  - Half with addr[0]=1, word with addr[1:0]!=00, or size 11 -> not enqueued; misaligned=1 for the following cycle.
  - If both apply, misaligned takes precedence over overflow.
- Overflow: st_valid while full -> store dropped; overflow set and held until reset.
- Lane formatting at enqueue, with o=addr[1:0]:
  - Byte: be=0001<<o, wdata=data[7:0]<<8*o.
  - Half: be=0011<<o, wdata=data[15:0]<<8*o.
  - Word: be=1111, wdata=data.
  - Entry stores {addr[31:2], wdata, be}.
- FSM IDLE/REQ:
  - IDLE: if the FIFO is non-empty, load the head into the output registers, set mem_req=1, go to REQ.
  - REQ: hold mem_addr/wdata/be/req stable until mem_gnt=1. On gnt, pop the head.
  - After gnt, if a further entry exists, load it the same edge and stay in REQ (back-to-back, one store per cycle at full rate); else mem_req=0 and go to IDLE.
- Latency: a store accepted at edge E into an empty, idle buffer shows mem_req=1 after edge E+1.
- Stores drain strictly in program order.
- ld_hazard (combinational):
  - 1 if any valid entry, including the in-flight head, has addr[31:2]==ld_addr[31:2].
  - Cleared in the cycle after the matching entry is granted.
- st_empty=1 only when count==0 and the FSM is in IDLE.
- Pointers carry log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; count is derived from them.

Decomposition:
- Shared package:
  - Size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD.
  - Packed struct store_entry_t {logic [29:0] waddr; logic [31:0] wdata; logic [3:0] be}.
- Sub-module store_fifo: parameterised by DEPTH, storing store_entry_t.
  - Ports: push, pop, head output, full/empty/count.
  - Exposes an entry-valid vector so the top level can do the hazard compare.

Test Plan:
- Byte store: addr 0x1003, data 0xAB, mem_gnt tied 1 -> mem_req one cycle after enqueue; mem_addr 0x1000, be 1000, wdata 0xAB000000.
- Four word stores to 0x0, 0x4, 0x8, 0xC with mem_gnt=0:
  - st_full=1 after the fourth.
  - A fifth store sets overflow=1 and is not enqueued.
  - Releasing gnt drains all four back-to-back in order.
- Half store to 0x2001 -> misaligned pulses for one cycle, no enqueue, st_empty stays 1.
- Pending word store to 0x40, ld_addr=0x42 -> ld_hazard=1; ld_addr=0x44 -> 0; after gnt of 0x40 -> ld_hazard=0.
- Reset asserted while mem_req=1 with 3 entries queued -> mem_req=0 asynchronously, st_empty=1; after reset release no requests issue.
- Store arriving in the same cycle as a grant at count==DEPTH -> store dropped, overflow=1; the head still pops.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: size encodings, queued entry
// layout, drain FSM states, and the alignment/lane-formatting rules.
package store_buffer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sb_state_t;

  // The reserved size encoding never counts as aligned.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~offset[0];
      SZ_WORD: ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic store_entry_t format_store(input logic [1:0]  size,
                                                input logic [31:0] addr,
                                                input logic [31:0] data);
    store_entry_t e;
    logic [1:0]   o;
    o       = addr[1:0];
    e.waddr = addr[31:2];
    case (size)
      SZ_BYTE: begin
        e.be    = 4'b0001 << o;
        e.wdata = {24'h0, data[7:0]} << {o, 3'b000};
      end
      SZ_HALF: begin
        e.be    = 4'b0011 << o;
        e.wdata = {16'h0, data[15:0]} << {o, 3'b000};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = data;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order queue of formatted store entries. Publishes the head, the entry
// behind it, and a per-slot valid vector with word addresses for alias checks.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  store_entry_t                push_entry,
  output store_entry_t                head,
  output store_entry_t                next_head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][29:0]      entry_waddr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] rel [DEPTH];
  store_entry_t  mem [DEPTH];

  assign rd_idx  = rd_ptr[AW-1:0];
  assign nxt_idx = rd_idx + AW'(1);

  // The extra pointer bit distinguishes full from empty when indices coincide.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign head      = mem[rd_idx];
  assign next_head = mem[nxt_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read index is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]         = AW'(i) - rd_idx;
      entry_valid[i] = ({1'b0, rel[i]} < count);
      entry_waddr[i] = mem[i].waddr;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store buffer: accepts aligned retire stores, drains them in order
// over req/gnt, and flags loads that alias any entry still queued or in flight.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_full,
  output logic        st_empty,
  output logic        misaligned,
  output logic        overflow,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard
);

  localparam int AW = $clog2(DEPTH);

  store_entry_t           push_entry;
  store_entry_t           head;
  store_entry_t           next_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            count;
  logic [DEPTH-1:0]       entry_valid;
  logic [DEPTH-1:0][29:0] entry_waddr;
  sb_state_t              state;
  logic                   aligned;
  logic                   push;
  logic                   pop;
  logic                   has_next;

  assign aligned    = size_aligned(st_size, st_addr[1:0]);
  assign push       = st_valid && aligned && !fifo_full;
  assign pop        = (state == REQ) && mem_gnt;
  assign has_next   = (count > (AW+1)'(1));
  assign push_entry = format_store(st_size, st_addr, st_data);

  store_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_entry  (push_entry),
    .head        (head),
    .next_head   (next_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_waddr (entry_waddr)
  );

  // The in-flight entry stays in the FIFO until granted, so on a grant the
  // successor is the slot behind the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mem_addr  <= {head.waddr, 2'b00};
            mem_wdata <= head.wdata;
            mem_be    <= head.be;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            if (has_next) begin
              mem_addr  <= {next_head.waddr, 2'b00};
              mem_wdata <= next_head.wdata;
              mem_be    <= next_head.be;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // A misaligned store is reported as misaligned only, never as overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      misaligned <= st_valid && !aligned;
      if (st_valid && aligned && fifo_full)
        overflow <= 1'b1;
    end
  end

  assign st_full  = fifo_full;
  assign st_empty = fifo_empty && (state == IDLE);

  // Byte offsets are carried along so the match is on the word address alone.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && ({entry_waddr[i], ld_addr[1:0]} == ld_addr))
        ld_hazard = 1'b1;
    end
  end

endmodule
